// File: rtl/msg_schedule.sv
// SHA-2 message-schedule expander: takes one 16-word block and streams W_0..W_{R-1}
// at one word per cycle. W=32 uses the SHA-256 sigma functions; W=64 uses the SHA-512 ones.
module msg_schedule #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         ABORT,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [0:W-1] IN_WORD,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [0:W-1] OUT_WORD,
  output logic [6:0]   OUT_INDEX,
  output logic         OUT_LAST,
  output logic         BUSY,
  output logic [1:0]   DBG_STATE
);

  localparam int R = (W == 64) ? 80 : 64;

  if (W != 32 && W != 64) begin : g_bad_width
    $error("msg_schedule: W must be 32 or 64");
  end

  // Handshake: a word moves on either port only in a cycle where valid && ready.
  // OUT_VALID/OUT_WORD never change while OUT_VALID && !OUT_READY.
  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_EXPAND = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [6:0]     t_q, t_d;
  logic [W-1:0]   win_q [16];
  logic [W-1:0]   win_d [16];
  logic [W-1:0]   out_word_q, out_word_d;
  logic [6:0]     out_index_q, out_index_d;
  logic           out_last_q, out_last_d;
  logic           out_valid_q, out_valid_d;

  logic           free;
  logic           load;
  logic [W-1:0]   load_word;
  logic [W-1:0]   w_new;
  logic [W-1:0]   in_word_le;
  logic [6:0]     idx;

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int n);
    return (x >> n) | (x << (W - n));
  endfunction

  function automatic logic [W-1:0] sigma0(input logic [W-1:0] x);
    if (W == 64) return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    else         return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [W-1:0] sigma1(input logic [W-1:0] x);
    if (W == 64) return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    else         return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // win_q[0] is W_{t-16}, win_q[15] is W_{t-1}.
  assign w_new      = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];
  assign in_word_le = IN_WORD;
  assign free       = !out_valid_q || OUT_READY;
  // DRAIN doubles as the first LOAD cycle of the next block, so blocks chain with no bubble.
  assign idx        = (state_q == S_DRAIN) ? 7'd0 : t_q;

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    win_d       = win_q;
    out_word_d  = out_word_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    IN_READY    = 1'b0;
    load        = 1'b0;
    load_word   = '0;

    case (state_q)
      S_LOAD: begin
        IN_READY = free;
        if (IN_VALID && free) begin
          load      = 1'b1;
          load_word = in_word_le;
        end
      end
      S_EXPAND: begin
        if (free) begin
          load      = 1'b1;
          load_word = w_new;
        end
      end
      S_DRAIN: begin
        IN_READY = OUT_READY;
        if (IN_VALID && OUT_READY) begin
          load      = 1'b1;
          load_word = in_word_le;
        end
      end
      default: ;
    endcase

    if (load) begin
      for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
      win_d[15]   = load_word;
      out_word_d  = load_word;
      out_index_d = idx;
      out_last_d  = (idx == 7'(R - 1));
      out_valid_d = 1'b1;
      t_d         = idx + 7'd1;
      if (idx == 7'(R - 1))  state_d = S_DRAIN;
      else if (idx >= 7'd15) state_d = S_EXPAND;
      else                   state_d = S_LOAD;
    end else if (OUT_READY) begin
      out_valid_d = 1'b0;
      if (state_q == S_DRAIN) begin
        t_d     = 7'd0;
        state_d = S_LOAD;
      end
    end

    if (ABORT) begin
      state_d     = S_LOAD;
      t_d         = 7'd0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_LOAD;
      t_q         <= 7'd0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
      out_word_q  <= '0;
      out_index_q <= 7'd0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      win_q       <= win_d;
      out_word_q  <= out_word_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_WORD  = out_word_q;
  assign OUT_INDEX = out_index_q;
  assign OUT_LAST  = out_last_q;
  assign BUSY      = !(state_q == S_LOAD && t_q == 7'd0 && !out_valid_q);
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_msg_schedule.sv
// Directed bench for msg_schedule: one W=32 and one W=64 instance sharing clock and reset.
module tb_msg_schedule;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        abort32, in_valid32, in_ready32, out_valid32, out_ready32, out_last32, busy32;
  logic [31:0] in_word32, out_word32;
  logic [6:0]  out_index32;
  logic [1:0]  dbg32;
  logic        abort64, in_valid64, in_ready64, out_valid64, out_ready64, out_last64, busy64;
  logic [63:0] in_word64, out_word64;
  logic [6:0]  out_index64;
  logic [1:0]  dbg64;

  msg_schedule #(.W(32)) u_d32 (
    .CLK(clk), .RST_N(rst_n), .ABORT(abort32), .IN_VALID(in_valid32), .IN_READY(in_ready32),
    .IN_WORD(in_word32), .OUT_VALID(out_valid32), .OUT_READY(out_ready32), .OUT_WORD(out_word32),
    .OUT_INDEX(out_index32), .OUT_LAST(out_last32), .BUSY(busy32), .DBG_STATE(dbg32)
  );

  msg_schedule #(.W(64)) u_d64 (
    .CLK(clk), .RST_N(rst_n), .ABORT(abort64), .IN_VALID(in_valid64), .IN_READY(in_ready64),
    .IN_WORD(in_word64), .OUT_VALID(out_valid64), .OUT_READY(out_ready64), .OUT_WORD(out_word64),
    .OUT_INDEX(out_index64), .OUT_LAST(out_last64), .BUSY(busy64), .DBG_STATE(dbg64)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  int          stall_bad;
  logic [63:0] blk [32];
  logic [63:0] exp_q [$];
  logic [63:0] cap_word [$];
  int          cap_idx [$];
  bit          cap_last [$];
  int          cap_cyc [$];
  logic [63:0] saved_abc [64];

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  task automatic model32(input int base);
    logic [31:0] w [64];
    logic [31:0] s0, s1;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = blk[base+t][31:0];
      else begin
        s0 = rotr32(w[t-15], 7) ^ rotr32(w[t-15], 18) ^ (w[t-15] >> 3);
        s1 = rotr32(w[t-2], 17) ^ rotr32(w[t-2], 19) ^ (w[t-2] >> 10);
        w[t] = s1 + w[t-7] + s0 + w[t-16];
      end
      exp_q.push_back({32'h0, w[t]});
    end
  endtask

  task automatic model64(input int base);
    logic [63:0] w [80];
    logic [63:0] s0, s1;
    for (int t = 0; t < 80; t++) begin
      if (t < 16) w[t] = blk[base+t];
      else begin
        s0 = rotr64(w[t-15], 1) ^ rotr64(w[t-15], 8) ^ (w[t-15] >> 7);
        s1 = rotr64(w[t-2], 19) ^ rotr64(w[t-2], 61) ^ (w[t-2] >> 6);
        w[t] = s1 + w[t-7] + s0 + w[t-16];
      end
      exp_q.push_back(w[t]);
    end
  endtask

  task automatic drive_in(input bit sel64, input bit v, input logic [63:0] w, input bit rdy);
    in_valid32  = v && !sel64;
    in_word32   = w[31:0];
    out_ready32 = sel64 ? 1'b1 : rdy;
    in_valid64  = v && sel64;
    in_word64   = w;
    out_ready64 = sel64 ? rdy : 1'b1;
  endtask

  // Streams nb blocks from blk[] into one DUT and captures accepted outputs until n_stop
  // words have been taken. Called just after a rising edge.
  task automatic drive(input bit sel64, input int nb, input bit rand_ready, input int n_stop);
    int          idx_in = 0;
    int          cyc = 0;
    bit          prev_stall = 0;
    logic [63:0] prev_word = '0;
    int          prev_idx = 0;
    bit          fire, ov, ordy, ir, iv, ol;
    logic [63:0] ow;
    int          oi;
    cap_word.delete(); cap_idx.delete(); cap_last.delete(); cap_cyc.delete();
    stall_bad = 0;
    drive_in(sel64, 1'b1, blk[0], rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    while (cap_word.size() < n_stop && cyc < 2000) begin
      @(negedge clk);
      ov   = sel64 ? out_valid64 : out_valid32;
      ordy = sel64 ? out_ready64 : out_ready32;
      ow   = sel64 ? out_word64 : {32'h0, out_word32};
      oi   = sel64 ? int'(out_index64) : int'(out_index32);
      ol   = sel64 ? out_last64 : out_last32;
      ir   = sel64 ? in_ready64 : in_ready32;
      iv   = sel64 ? in_valid64 : in_valid32;
      if (prev_stall && (!ov || ow !== prev_word || oi != prev_idx)) stall_bad++;
      if (ov && !ordy && ir) stall_bad++;
      prev_stall = ov && !ordy;
      prev_word  = ow;
      prev_idx   = oi;
      if (ov && ordy) begin
        cap_word.push_back(ow); cap_idx.push_back(oi);
        cap_last.push_back(ol); cap_cyc.push_back(cyc);
      end
      fire = iv && ir;
      @(posedge clk); #1;
      cyc++;
      if (fire) idx_in++;
      drive_in(sel64, idx_in < 16 * nb, (idx_in < 32) ? blk[idx_in] : 64'h0,
               rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    end
    drive_in(sel64, 1'b0, 64'h0, 1'b1);
    n_vec++;
    if (cap_word.size() < n_stop) begin
      n_bad++;
      $display("FAIL drive_timeout: got %0d words, want %0d", cap_word.size(), n_stop);
    end
  endtask

  task automatic load_abc(input int base);
    for (int i = 0; i < 16; i++) blk[base+i] = 64'h0;
    blk[base]    = 64'h61626380;
    blk[base+15] = 64'h18;
  endtask

  task automatic test_reset;
    logic [44:0] got32, want32;
    logic [76:0] got64, want64;
    rst_n = 1'b0;
    drive_in(1'b0, 1'b0, 64'h0, 1'b1);
    abort32 = 1'b0; abort64 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got32  = {out_valid32, out_word32, out_index32, out_last32, in_ready32, busy32, dbg32};
    want32 = {1'b0, 32'h0, 7'd0, 1'b0, 1'b1, 1'b0, 2'd0};
    n_vec++;
    if (got32 !== want32) begin
      n_bad++; $display("FAIL reset_w32: got %h want %h", got32, want32);
    end
    got64  = {out_valid64, out_word64, out_index64, out_last64, in_ready64, busy64, dbg64};
    want64 = {1'b0, 64'h0, 7'd0, 1'b0, 1'b1, 1'b0, 2'd0};
    n_vec++;
    if (got64 !== want64) begin
      n_bad++; $display("FAIL reset_w64: got %h want %h", got64, want64);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_abc_block;
    load_abc(0);
    exp_q.delete(); model32(0);
    drive(1'b0, 1, 1'b0, 64);
    for (int i = 0; i < 64; i++) begin
      n_vec++;
      if (cap_word[i] !== exp_q[i] || cap_idx[i] != i || cap_last[i] != (i == 63)) begin
        n_bad++;
        $display("FAIL abc_word[%0d]: got %h idx %0d last %0d want %h idx %0d last %0d",
                 i, cap_word[i], cap_idx[i], cap_last[i], exp_q[i], i, (i == 63));
      end
      saved_abc[i] = cap_word[i];
    end
    n_vec++;
    if (cap_word[16] !== 64'h61626380 || cap_word[17] !== 64'h000F0000) begin
      n_bad++; $display("FAIL abc_w16_w17: got %h %h want 61626380 000f0000", cap_word[16], cap_word[17]);
    end
    n_vec++;
    if (cap_cyc[0] != 1 || cap_cyc[63] != 64) begin
      n_bad++; $display("FAIL abc_timing: first %0d last %0d want 1 64", cap_cyc[0], cap_cyc[63]);
    end
    @(negedge clk);
    n_vec++;
    if (out_valid32 !== 1'b0 || busy32 !== 1'b0 || in_ready32 !== 1'b1) begin
      n_bad++; $display("FAIL abc_idle: valid %b busy %b ready %b want 0 0 1", out_valid32, busy32, in_ready32);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ones32;
    for (int i = 0; i < 16; i++) blk[i] = 64'hFFFFFFFF;
    exp_q.delete(); model32(0);
    drive(1'b0, 1, 1'b0, 64);
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (cap_word[i] !== 64'hFFFFFFFF) begin
        n_bad++; $display("FAIL ones32_pass[%0d]: got %h want ffffffff", i, cap_word[i]);
      end
    end
    n_vec++;
    if (cap_word[16] !== 64'h203FFFFC) begin
      n_bad++; $display("FAIL ones32_w16: got %h want 203ffffc", cap_word[16]);
    end
    for (int i = 17; i < 64; i++) begin
      n_vec++;
      if (cap_word[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL ones32_word[%0d]: got %h want %h", i, cap_word[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_ones64;
    for (int i = 0; i < 16; i++) blk[i] = '1;
    exp_q.delete(); model64(0);
    drive(1'b1, 1, 1'b0, 80);
    n_vec++;
    if (cap_word[16] !== 64'h05FFFFFFFFFFFFFC) begin
      n_bad++; $display("FAIL ones64_w16: got %h want 05fffffffffffffc", cap_word[16]);
    end
    for (int i = 0; i < 80; i++) begin
      n_vec++;
      if (cap_word[i] !== exp_q[i] || cap_idx[i] != i || cap_last[i] != (i == 79)) begin
        n_bad++;
        $display("FAIL ones64_word[%0d]: got %h idx %0d last %0d want %h idx %0d last %0d",
                 i, cap_word[i], cap_idx[i], cap_last[i], exp_q[i], i, (i == 79));
      end
    end
  endtask

  task automatic test_backpressure;
    load_abc(0);
    drive(1'b0, 1, 1'b1, 64);
    for (int i = 0; i < 64; i++) begin
      n_vec++;
      if (cap_word[i] !== saved_abc[i] || cap_idx[i] != i) begin
        n_bad++; $display("FAIL stall_word[%0d]: got %h idx %0d want %h idx %0d",
                          i, cap_word[i], cap_idx[i], saved_abc[i], i);
      end
    end
    n_vec++;
    if (stall_bad != 0) begin
      n_bad++; $display("FAIL stall_hold: got %0d violations want 0", stall_bad);
    end
  endtask

  task automatic test_abort;
    load_abc(0);
    drive(1'b0, 1, 1'b0, 21);
    abort32 = 1'b1; in_valid32 = 1'b1; in_word32 = 32'hDEADBEEF; out_ready32 = 1'b1;
    @(posedge clk); #1;
    abort32 = 1'b0; in_valid32 = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out_valid32 !== 1'b0) begin
      n_bad++; $display("FAIL abort_valid: got %b want 0", out_valid32);
    end
    n_vec++;
    if (in_ready32 !== 1'b1) begin
      n_bad++; $display("FAIL abort_ready: got %b want 1", in_ready32);
    end
    n_vec++;
    if (busy32 !== 1'b0) begin
      n_bad++; $display("FAIL abort_busy: got %b want 0", busy32);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) blk[i] = 64'h0;
    drive(1'b0, 1, 1'b0, 64);
    for (int i = 0; i < 64; i++) begin
      n_vec++;
      if (cap_word[i] !== 64'h0 || cap_idx[i] != i) begin
        n_bad++; $display("FAIL abort_zero[%0d]: got %h idx %0d want 0 idx %0d", i, cap_word[i], cap_idx[i], i);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [44:0] got32, want32;
    load_abc(0);
    drive(1'b0, 1, 1'b0, 41);
    #2;
    rst_n = 1'b0;
    #1;
    got32  = {out_valid32, out_word32, out_index32, out_last32, in_ready32, busy32, dbg32};
    want32 = {1'b0, 32'h0, 7'd0, 1'b0, 1'b1, 1'b0, 2'd0};
    n_vec++;
    if (got32 !== want32) begin
      n_bad++; $display("FAIL midreset_async: got %h want %h", got32, want32);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_abc(0);
    for (int i = 16; i < 32; i++) blk[i] = 64'hFFFFFFFF;
    exp_q.delete(); model32(0); model32(16);
    drive(1'b0, 2, 1'b0, 128);
    for (int i = 0; i < 128; i++) begin
      n_vec++;
      if (cap_word[i] !== exp_q[i] || cap_idx[i] != (i % 64)) begin
        n_bad++; $display("FAIL b2b_word[%0d]: got %h idx %0d want %h idx %0d",
                          i, cap_word[i], cap_idx[i], exp_q[i], i % 64);
      end
    end
    n_vec++;
    if (cap_cyc[64] - cap_cyc[63] != 1) begin
      n_bad++; $display("FAIL b2b_gap: got %0d cycles want 1", cap_cyc[64] - cap_cyc[63]);
    end
  endtask

  initial begin
    test_reset();
    test_abc_block();
    test_ones32();
    test_ones64();
    test_backpressure();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
